xunitm_ctrl: RTL and testbench
==============================

// Module: xunitm_ctrl
// PURPOSE
// Sequencer for the xunitM message-schedule functional unit. Accepts one block of NWORDS
// words over a valid/ready stream, configures xunitM's delay, pulses run, feeds the words
// on consecutive cycles, captures NWORDS results at the fixed latency and returns them
// over a second valid/ready stream. One block in flight; sits between host/DMA and xunitM.
// PARAMETERS
// DATA_W   32  word width
// NWORDS   16  words per block in and out (power of 2)
// LATENCY  17  xunitM latency, cycles from run edge to first result (excluding delay)
// DELAY_W  8   width of xunitM delay configuration
// PORTS
// clk        in   1        clock, all state on rising edge
// rst        in   1        asynchronous, active-high reset
// cfg_delay  in   DELAY_W  delay for next block; sampled on first accepted input word
// in_valid   in   1        input word valid
// in_ready   out  1        controller accepts an input word
// in_data    in   DATA_W   input word
// out_valid  out  1        result word valid
// out_ready  in   1        consumer accepts result word
// out_data   out  DATA_W   result word
// busy       out  1        high in any state other than IDLE
// done       out  1        one-cycle pulse after last result handshake
// xu_run     out  1        to xunitM run
// xu_delay0  out  DELAY_W  to xunitM delay0
// xu_in0     out  DATA_W   to xunitM in0
// xu_out0    in   DATA_W   from xunitM out0
// BEHAVIOUR
// Reset (async): state=IDLE; in_ready=1, out_valid=0, busy=0, done=0, xu_run=0,
//   xu_delay0=0, xu_in0=0, out_data=0; counters=0; buffers not cleared.
// States: IDLE -> LOAD -> RUN -> EXEC -> DRAIN -> IDLE.
// IDLE: in_ready=1. Handshake: store word at in_buf[0], latch cfg_delay into dly_r,
//   drive xu_delay0=dly_r, idx=1, go LOAD.
// LOAD: in_ready=1; each handshake writes in_buf[idx], idx++. Handshake with
//   idx==NWORDS-1 -> RUN. Bubbles on in_valid allowed, no timeout.
// RUN: in_ready=0; xu_run=1 for exactly this cycle; timer t<=0 on the edge ending RUN
//   (call that edge E0). -> EXEC.
// EXEC: t increments each edge. Feed window: xu_in0=in_buf[i] stable for edge E(1+i),
//   i=0..NWORDS-1; xu_in0=0 outside window. Capture: out_buf[j]<=xu_out0 at edge
//   E(dly_r+LATENCY+1+j), j=0..NWORDS-1. Windows are independent and may overlap.
//   After last capture -> DRAIN, rd=0. Timer width DELAY_W+6, no wrap possible.
// DRAIN: out_valid=1, out_data=out_buf[rd]; rd++ on handshake; out_data stable while
//   out_ready=0. Handshake at rd==NWORDS-1 -> IDLE, done=1 next cycle.
// xu_delay0 holds dly_r from IDLE-handshake until DRAIN exit; cfg_delay changes
//   mid-block ignored. in_valid ignored outside IDLE/LOAD (in_ready=0).
// done and a new IDLE handshake in same cycle are legal; next block proceeds.
// Reset mid-block: partial block discarded, no done, outputs to reset values at once.
// Index counters log2(NWORDS) bits; terminal compare prevents wrap.
// TESTING
// 1) Load 16 words of xunitM_in.bin, delay 0, out_ready=1 -> xu_run single pulse,
//    16 results match xunitM_out.bin, done pulses once.
// 2) delay=5 -> first capture at E23, last at E38 (behavioural xunitM model check).
// 3) in_valid random 50% gaps, out_ready toggling -> same 16 results in order, no drop/dup.
// 4) cfg_delay changed 3->9 during LOAD -> xu_delay0 stays 3, captures at E21..E36.
// 5) assert rst at t=E10 of EXEC -> busy=0, xu_run=0, out_valid=0 immediately; next
//    clean block passes.
// 6) Two back-to-back blocks, second in_valid already high at done -> both outputs correct.

Source files
------------

// File: rtl/xunitm_ctrl.sv
// Block sequencer for the xunitM message-schedule unit: buffers one input block, runs xunitM,
// captures its results at the configured latency and streams them back out.
module xunitm_ctrl #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NWORDS  = 16,
    parameter int unsigned LATENCY = 17,
    parameter int unsigned DELAY_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DELAY_W-1:0] cfg_delay_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [DATA_W-1:0]  in_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DATA_W-1:0]  out_data_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               xu_run_o,
    output logic [DELAY_W-1:0] xu_delay0_o,
    output logic [DATA_W-1:0]  xu_in0_o,
    input  logic [DATA_W-1:0]  xu_out0_i
);

    localparam int unsigned IW = $clog2(NWORDS);
    localparam int unsigned TW = DELAY_W + 6;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StExec,
        StDrain
    } state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [IW-1:0]      rd_q, rd_d;
    logic [TW-1:0]      t_q, t_d;
    logic [DELAY_W-1:0] dly_q, dly_d;
    logic               done_q, done_d;

    logic [DATA_W-1:0]  in_buf_q  [NWORDS];
    logic [DATA_W-1:0]  out_buf_q [NWORDS];

    logic               in_hs;
    logic               feed;
    logic               cap_en;
    logic               last_cap;
    logic [TW-1:0]      cap_base;
    logic [TW-1:0]      cap_off;

    // Feed and capture windows are both keyed off the same timer so they may overlap freely.
    always_comb begin
        cap_base = TW'(dly_q) + TW'(LATENCY);
        cap_off  = t_q - cap_base;
        feed     = (state_q == StExec) && (t_q < TW'(NWORDS));
        cap_en   = (state_q == StExec) && (t_q >= cap_base) && (cap_off < TW'(NWORDS));
        last_cap = cap_en && (cap_off == TW'(NWORDS - 1));
        in_hs    = in_valid_i && in_ready_o;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rd_d        = rd_q;
        t_d         = t_q;
        dly_d       = dly_q;
        done_d      = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        xu_run_o    = 1'b0;
        xu_in0_o    = '0;

        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    dly_d   = cfg_delay_i;
                    idx_d   = IW'(1);
                    state_d = StLoad;
                end
            end
            StLoad: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    if (idx_q == IW'(NWORDS - 1)) begin
                        idx_d   = '0;
                        state_d = StRun;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            StRun: begin
                xu_run_o = 1'b1;
                t_d      = '0;
                state_d  = StExec;
            end
            StExec: begin
                t_d = t_q + TW'(1);
                if (feed) begin
                    xu_in0_o = in_buf_q[t_q[IW-1:0]];
                end
                if (last_cap) begin
                    rd_d    = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                out_valid_o = 1'b1;
                out_data_o  = out_buf_q[rd_q];
                if (out_ready_i) begin
                    if (rd_q == IW'(NWORDS - 1)) begin
                        rd_d    = '0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        rd_d = rd_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            rd_q    <= '0;
            t_q     <= '0;
            dly_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            t_q     <= t_d;
            dly_q   <= dly_d;
            done_q  <= done_d;
        end
    end

    // Data buffers carry no reset; contents are only read after being written in the block.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            in_buf_q[idx_q] <= in_data_i;
        end
        if (cap_en) begin
            out_buf_q[cap_off[IW-1:0]] <= xu_out0_i;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign xu_delay0_o = dly_q;

endmodule

// File: tb/tb_xunitm_ctrl.sv
// Self-checking bench for xunitm_ctrl with a behavioural xunitM model (fixed delay + transform).
module tb_xunitm_ctrl;

    localparam int DW  = 32;
    localparam int NW  = 16;
    localparam int LAT = 17;
    localparam int DLW = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [DLW-1:0] cfg_delay = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [DW-1:0]  in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [DW-1:0]  out_data;
    logic           busy;
    logic           done;
    logic           xu_run;
    logic [DLW-1:0] xu_delay0;
    logic [DW-1:0]  xu_in0;
    logic [DW-1:0]  xu_out0;

    always #5 clk = ~clk;

    xunitm_ctrl #(
        .DATA_W (DW),
        .NWORDS (NW),
        .LATENCY(LAT),
        .DELAY_W(DLW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_delay_i(cfg_delay),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .busy_o     (busy),
        .done_o     (done),
        .xu_run_o   (xu_run),
        .xu_delay0_o(xu_delay0),
        .xu_in0_o   (xu_in0),
        .xu_out0_i  (xu_out0)
    );

    function automatic logic [31:0] fx(input logic [31:0] x);
        return {x[19:0], x[31:20]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [31:0] word(input int seed, input int w);
        return 32'(seed) * 32'h9E37_79B9 + 32'(w) * 32'h0101_0103;
    endfunction

    // xunitM model: a word sampled on edge E(1+i) is presented D+LAT edges later.
    logic [DW-1:0] hist [0:511];
    always @(posedge clk) begin
        for (int i = 511; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= xu_in0;
    end
    assign xu_out0 = fx(hist[int'(xu_delay0) + LAT - 1]);

    int       checks = 0;
    int       errors = 0;
    int       ecnt = 0;
    int       run_cnt = 0;
    int       done_cnt = 0;
    int       overlap_cnt = 0;
    int       first_ov = 0;
    int       ov_dly = 0;
    bit       ov_seen = 1'b0;
    logic [31:0] expq[$];

    always @(posedge clk) begin
        if (xu_run) ecnt <= 0;
        else ecnt <= ecnt + 1;
        if (xu_run) run_cnt <= run_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    always @(negedge clk) begin
        if (out_valid && !ov_seen) begin
            ov_seen  = 1'b1;
            first_ov = ecnt;
            ov_dly   = int'(xu_delay0);
        end
        if (done && in_valid && in_ready) overlap_cnt = overlap_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_block(input int dly, input int chg, input int seed, input bit gaps);
        int n;
        for (int w = 0; w < NW; w++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid  = 1'b1;
            in_data   = word(seed, w);
            cfg_delay = (w == 0) ? DLW'(dly) : DLW'(chg);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!in_ready && n < 4000);
            if (!in_ready) begin
                check("in_ready_timeout", 64'd0, 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            expq.push_back(fx(word(seed, w)));
        end
        in_valid = 1'b0;
    endtask

    task automatic recv(input int n, input bit bp);
        int got = 0;
        int k = 0;
        bit holding = 1'b0;
        logic [31:0] held = '0;
        logic [31:0] exp;
        while (got < n && k < n * 600) begin
            @(negedge clk);
            k++;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && holding) check("out_data_stable", out_data, held);
            holding = 1'b0;
            if (out_valid && !out_ready) begin
                holding = 1'b1;
                held    = out_data;
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_result", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp = expq.pop_front();
                    check("result", out_data, exp);
                end
                got++;
            end
        end
        if (got < n) check("recv_timeout", got, n);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    typedef struct {
        int dly;
        int chg;
        bit gaps;
        bit bp;
        int seed;
        int exp_ov_edge;
        int exp_dly;
    } blk_t;

    blk_t tbl [5];
    int   d0, r0;

    initial begin
        for (int i = 0; i < 512; i++) hist[i] = '0;

        tbl[0] = '{dly: 0,   chg: 0, gaps: 1'b0, bp: 1'b0, seed: 1000, exp_ov_edge: 33,  exp_dly: 0};
        tbl[1] = '{dly: 5,   chg: 5, gaps: 1'b0, bp: 1'b0, seed: 2000, exp_ov_edge: 38,  exp_dly: 5};
        tbl[2] = '{dly: 2,   chg: 2, gaps: 1'b1, bp: 1'b1, seed: 3000, exp_ov_edge: 35,  exp_dly: 2};
        tbl[3] = '{dly: 3,   chg: 9, gaps: 1'b1, bp: 1'b0, seed: 4000, exp_ov_edge: 36,  exp_dly: 3};
        tbl[4] = '{dly: 255, chg: 0, gaps: 1'b0, bp: 1'b1, seed: 5000, exp_ov_edge: 288, exp_dly: 255};

        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_xu_run", xu_run, 0);
        check("rst_xu_delay0", xu_delay0, 0);
        check("rst_xu_in0", xu_in0, 0);
        check("rst_out_data", out_data, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int b = 0; b < 5; b++) begin
            d0 = done_cnt;
            r0 = run_cnt;
            ov_seen = 1'b0;
            fork
                send_block(tbl[b].dly, tbl[b].chg, tbl[b].seed, tbl[b].gaps);
                recv(NW, tbl[b].bp);
            join
            repeat (2) @(posedge clk);
            #1;
            check("run_pulses", run_cnt - r0, 1);
            check("done_pulses", done_cnt - d0, 1);
            check("first_out_valid_edge", first_ov, tbl[b].exp_ov_edge);
            check("xu_delay0_in_drain", ov_dly, tbl[b].exp_dly);
            check("idle_after_block", busy, 0);
            check("queue_empty", expq.size(), 0);
        end

        // Reset asserted after edge E10 of EXEC.
        d0 = done_cnt;
        send_block(0, 0, 6000, 1'b0);
        begin
            int k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (ecnt != 10 && k < 100);
            check("reach_E10", ecnt, 10);
        end
        #1 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_xu_run", xu_run, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_xu_in0", xu_in0, 0);
        check("midrst_xu_delay0", xu_delay0, 0);
        @(negedge clk);
        rst = 1'b0;
        expq.delete();
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_still_idle", busy, 0);

        d0 = done_cnt;
        ov_seen = 1'b0;
        fork
            send_block(1, 1, 6500, 1'b0);
            recv(NW, 1'b0);
        join
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_done", done_cnt - d0, 1);
        check("post_rst_ov_edge", first_ov, 34);

        // Back-to-back: the second block's first word is already waiting when done fires.
        d0 = done_cnt;
        r0 = run_cnt;
        overlap_cnt = 0;
        fork
            begin
                send_block(4, 4, 7000, 1'b0);
                send_block(1, 1, 8000, 1'b0);
            end
            recv(2 * NW, 1'b0);
        join
        repeat (2) @(posedge clk);
        #1;
        check("b2b_done_pulses", done_cnt - d0, 2);
        check("b2b_run_pulses", run_cnt - r0, 2);
        check("b2b_done_with_handshake", overlap_cnt, 1);
        check("b2b_queue_empty", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
